// File: rtl/serial_in_parallel_out_rx_if.sv
// Serial-bit input side and parallel-word output side of the deserializer.
// The master drives serial bits and consumer controls; the slave returns the word.
interface serial_in_parallel_out_rx_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH);

  logic             i_sdata;
  logic             i_sen;
  logic             i_sync;
  logic             i_rd_ready;
  logic             i_clr_ovr;
  logic [WIDTH-1:0] o_q;
  logic             o_valid;
  logic             o_overrun;
  logic [CW-1:0]    o_bit_cnt;

  modport master (
    output i_sdata, i_sen, i_sync, i_rd_ready, i_clr_ovr,
    input  o_q, o_valid, o_overrun, o_bit_cnt
  );

  modport slave (
    input  i_sdata, i_sen, i_sync, i_rd_ready, i_clr_ovr,
    output o_q, o_valid, o_overrun, o_bit_cnt
  );
endinterface

// File: rtl/serial_in_parallel_out_rx.sv
// Deserializer: assembles WIDTH-bit words from qualified serial bits and holds
// each finished word behind a valid/ready handshake, flagging dropped words.
module serial_in_parallel_out_rx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_in_parallel_out_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic {COLLECT, LAST} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             ovr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;

  // LSB-first enters at the top and shifts right so the first bit lands in bit 0.
  always_comb begin
    if (LSB_FIRST) begin
      shifted    = {bus.i_sdata, sreg[WIDTH-1:1]};
      first_word = {bus.i_sdata, {(WIDTH-1){1'b0}}};
    end else begin
      shifted    = {sreg[WIDTH-2:0], bus.i_sdata};
      first_word = {{(WIDTH-1){1'b0}}, bus.i_sdata};
    end
  end

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= COLLECT;
      sreg  <= '0;
      cnt   <= '0;
      q     <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (valid && bus.i_rd_ready)
        valid <= 1'b0;
      if (bus.i_clr_ovr)
        ovr <= 1'b0;

      if (bus.i_sync) begin
        // Realignment never completes a word, even from LAST.
        sreg  <= bus.i_sen ? first_word : '0;
        cnt   <= bus.i_sen ? ONE : '0;
        state <= (bus.i_sen && (ONE == LAST_IDX)) ? LAST : COLLECT;
      end else if (bus.i_sen) begin
        case (state)
          COLLECT: begin
            sreg  <= shifted;
            cnt   <= cnt_inc;
            state <= (cnt_inc == LAST_IDX) ? LAST : COLLECT;
          end
          LAST: begin
            sreg  <= '0;
            cnt   <= '0;
            state <= COLLECT;
            // A word may replace the held one only if it leaves on this edge.
            if (!valid || bus.i_rd_ready) begin
              q     <= shifted;
              valid <= 1'b1;
            end else begin
              ovr <= 1'b1;
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

  assign bus.o_q       = q;
  assign bus.o_valid   = valid;
  assign bus.o_overrun = ovr;
  assign bus.o_bit_cnt = cnt;
endmodule

// File: tb/tb_serial_in_parallel_out_rx.sv
// Drives an LSB-first and an MSB-first receiver with identical bit streams and
// compares both against a bit-queue model of word assembly and handshake.
module tb_serial_in_parallel_out_rx;
  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic rst, sd, sen, syn, rdy, clr;

  serial_in_parallel_out_rx_if #(.WIDTH(W)) bl ();
  serial_in_parallel_out_rx_if #(.WIDTH(W)) bm ();

  assign bl.i_sdata = sd;  assign bm.i_sdata = sd;
  assign bl.i_sen = sen;   assign bm.i_sen = sen;
  assign bl.i_sync = syn;  assign bm.i_sync = syn;
  assign bl.i_rd_ready = rdy; assign bm.i_rd_ready = rdy;
  assign bl.i_clr_ovr = clr;  assign bm.i_clr_ovr = clr;

  serial_in_parallel_out_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(gclk), .i_rst(rst), .bus(bl.slave));
  serial_in_parallel_out_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(gclk), .i_rst(rst), .bus(bm.slave));

  int n_vec = 0;
  int n_err = 0;

  // Reference state: received bits of the partial word, in arrival order.
  bit           mb[$];
  logic [W-1:0] mq_l, mq_m;
  logic         mv, mov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic d, input logic e, input logic s,
                       input logic r, input logic c, input logic x);
    logic [W-1:0] wl, wm;
    bit done, set_ov;
    done = 0; set_ov = 0;
    if (x) begin
      mb.delete(); mq_l = '0; mq_m = '0; mv = 0; mov = 0;
      return;
    end
    if (s) begin
      mb.delete();
      if (e) mb.push_back(d);
    end else if (e) begin
      mb.push_back(d);
      if (mb.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wl[i]       = mb[i];
          wm[W-1-i]   = mb[i];
        end
        mb.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!mv || r) begin mq_l = wl; mq_m = wm; mv = 1; end
      else set_ov = 1;
    end else if (mv && r) begin
      mv = 0;
    end
    if (c) mov = 0;
    if (set_ov) mov = 1;
  endtask

  task automatic cyc(input logic d, input logic e, input logic s,
                     input logic r, input logic c, input logic x);
    sd = d; sen = e; syn = s; rdy = r; clr = c; rst = x;
    @(posedge gclk);
    model(d, e, s, r, c, x);
    #1;
    chk("q_lsb",     32'(bl.o_q),       32'(mq_l));
    chk("q_msb",     32'(bm.o_q),       32'(mq_m));
    chk("valid_lsb", 32'(bl.o_valid),   32'(mv));
    chk("valid_msb", 32'(bm.o_valid),   32'(mv));
    chk("ovr_lsb",   32'(bl.o_overrun), 32'(mov));
    chk("ovr_msb",   32'(bm.o_overrun), 32'(mov));
    chk("cnt_lsb",   32'(bl.o_bit_cnt), 32'(mb.size()));
    chk("cnt_msb",   32'(bm.o_bit_cnt), 32'(mb.size()));
  endtask

  // Sends v bit 0 first; rdy_last applies only on the completing bit.
  task automatic send_word(input logic [W-1:0] v, input logic r, input logic rdy_last);
    for (int i = 0; i < W; i++)
      cyc(v[i], 1'b1, 1'b0, (i == W-1) ? rdy_last : r, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic r, input logic c);
    cyc(1'b0, 1'b0, 1'b0, r, c, 1'b0);
  endtask

  initial begin
    logic [W-1:0] b1011;
    b1011 = 4'b1101;  // bit i is the i-th bit sent: 1,0,1,1
    sd = 0; sen = 0; syn = 0; rdy = 0; clr = 0; rst = 1;
    mb.delete(); mq_l = '0; mq_m = '0; mv = 0; mov = 0;

    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_q", 32'(bl.o_q), 32'h0);

    send_word(b1011, 0, 0);
    chk("plan_lsb_D", 32'(bl.o_q), 32'hD);
    chk("plan_msb_B", 32'(bm.o_q), 32'hB);
    chk("plan_cnt0",  32'(bl.o_bit_cnt), 32'h0);
    idle(1, 0);
    chk("plan_taken", 32'(bl.o_valid), 32'h0);

    for (int i = 0; i < 2*W; i++)
      cyc(b1011[i/2], (i % 2) == 0, 0, 0, 0, 0);
    chk("gap_msb_B", 32'(bm.o_q), 32'hB);
    idle(1, 0);

    send_word(4'h3, 0, 0);
    send_word(4'hA, 0, 0);
    chk("ovr_hold3", 32'(bl.o_q), 32'h3);
    chk("ovr_set",   32'(bl.o_overrun), 32'h1);
    idle(1, 0);
    idle(0, 1);
    chk("ovr_clr",   32'(bl.o_overrun), 32'h0);

    send_word(4'h5, 0, 0);
    send_word(4'h6, 0, 1);
    chk("b2b_q6",  32'(bl.o_q), 32'h6);
    chk("b2b_ovr", 32'(bl.o_overrun), 32'h0);
    idle(1, 0);

    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("sync_cnt1", 32'(bl.o_bit_cnt), 32'h1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("sync_lsb1", 32'(bl.o_q), 32'h1);
    chk("sync_msb8", 32'(bm.o_q), 32'h8);

    send_word(4'h7, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("pre_rst_ovr", 32'(bl.o_overrun), 32'h1);
    cyc(1, 1, 1, 1, 1, 1);
    chk("rst_mid_q", 32'(bl.o_q), 32'h0);
    send_word(4'h9, 0, 0);
    chk("fresh_q9", 32'(bl.o_q), 32'h9);

    // Same-edge clear and new overrun: set must win.
    send_word(4'h2, 0, 0);
    for (int i = 0; i < W; i++) cyc(1, 1, 0, 0, (i == W-1), 0);
    chk("ovr_set_wins", 32'(bl.o_overrun), 32'h1);

    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4,
          $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
